// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, SR/Cause field positions,
// exception codes and the read value for unimplemented registers.
package cp0_pkg;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_SR      = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;

    localparam int SR_IE         = 0;
    localparam int SR_EXL        = 1;
    localparam int SR_IM_LSB     = 10;
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_IP_LSB  = 10;
    localparam int CAUSE_TI      = 30;
    localparam int CAUSE_BD      = 31;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_MOD  = 5'd1,
        EXC_TLBL = 5'd2,
        EXC_TLBS = 5'd3,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    localparam logic [31:0] DEFAULT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/cp0_timer_cnt.sv
// Free-running Count, Compare and the sticky timer-interrupt flag TI.
module cp0_timer_cnt (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_count,
    input  logic        we_compare,
    input  logic [31:0] data_i,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q, ti_d;

    always_comb begin
        count_d   = we_count ? data_i : count_q + 32'd1;
        compare_d = we_compare ? data_i : compare_q;
        ti_d      = ti_q;
        // A Compare write acknowledges the timer, even if it matches this cycle.
        if (we_compare) begin
            ti_d = 1'b0;
        end else if ((count_q == compare_q) && (compare_q != 32'd0)) begin
            ti_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;

endmodule

// File: rtl/cp0_timer.sv
// CP0 subset: SR/Cause/EPC/PRId, exception and interrupt entry, ERET,
// and the Count/Compare timer folded onto one hardware interrupt line.
module cp0_timer
    import cp0_pkg::*;
#(
    parameter int          N_HWINT    = 6,
    parameter logic [31:0] PRID       = 32'h2333_6666,
    parameter int          TIMER_LINE = N_HWINT - 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [4:0]         addr_r,
    input  logic [4:0]         addr_w,
    input  logic [31:0]        data_i,
    output logic [31:0]        data_o,
    input  logic [31:0]        pc,
    input  logic               bd,
    input  logic               exc_valid,
    input  logic [4:0]         exc_code,
    input  logic [N_HWINT-1:0] hw_int,
    input  logic               eret,
    output logic               take,
    output logic [31:0]        epc
);

    logic               ie_q, ie_d;
    logic               exl_q, exl_d;
    logic [N_HWINT-1:0] im_q, im_d;
    logic [N_HWINT-1:0] ip_q, ip_d;
    logic [4:0]         exccode_q, exccode_d;
    logic               bd_q, bd_d;
    logic [31:0]        epc_q, epc_d;

    logic [31:0]        count, compare;
    logic               ti;
    logic               int_pending;
    logic [N_HWINT-1:0] ip_sample;
    logic [31:0]        sr_rd, cause_rd;

    cp0_timer_cnt u_cnt (
        .clk        (clk),
        .reset      (reset),
        .we_count   (we && (addr_w == REG_COUNT)),
        .we_compare (we && (addr_w == REG_COMPARE)),
        .data_i     (data_i),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    always_comb begin
        int_pending = (|(ip_q & im_q)) & ie_q & ~exl_q;
        take        = (exc_valid | int_pending) & ~exl_q;
        ip_sample             = hw_int;
        ip_sample[TIMER_LINE] = hw_int[TIMER_LINE] | ti;
    end

    always_comb begin
        ie_d      = ie_q;
        exl_d     = exl_q;
        im_d      = im_q;
        ip_d      = ip_q;
        exccode_d = exccode_q;
        bd_d      = bd_q;
        epc_d     = epc_q;
        if (we && (addr_w == REG_SR)) begin
            ie_d  = data_i[SR_IE];
            exl_d = data_i[SR_EXL];
            im_d  = data_i[SR_IM_LSB +: N_HWINT];
        end
        if (we && (addr_w == REG_EPC)) begin
            epc_d = data_i;
        end
        // IP freezes inside a handler so software sees what caused the entry.
        if (!exl_q) begin
            ip_d = ip_sample;
        end
        if (eret) begin
            exl_d = 1'b0;
        end
        // Handler entry overrides any concurrent MTC0 or ERET.
        if (take) begin
            exl_d     = 1'b1;
            bd_d      = bd;
            epc_d     = bd ? pc - 32'd4 : pc;
            exccode_d = exc_valid ? exc_code : EXC_INT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ie_q      <= 1'b1;
            exl_q     <= 1'b0;
            im_q      <= '1;
            ip_q      <= '0;
            exccode_q <= 5'd0;
            bd_q      <= 1'b0;
            epc_q     <= 32'd0;
        end else begin
            ie_q      <= ie_d;
            exl_q     <= exl_d;
            im_q      <= im_d;
            ip_q      <= ip_d;
            exccode_q <= exccode_d;
            bd_q      <= bd_d;
            epc_q     <= epc_d;
        end
    end

    always_comb begin
        sr_rd                            = 32'd0;
        sr_rd[SR_IE]                     = ie_q;
        sr_rd[SR_EXL]                    = exl_q;
        sr_rd[SR_IM_LSB +: N_HWINT]      = im_q;
        cause_rd                         = 32'd0;
        cause_rd[CAUSE_EXC_LSB +: 5]     = exccode_q;
        cause_rd[CAUSE_IP_LSB +: N_HWINT] = ip_q;
        cause_rd[CAUSE_TI]               = ti;
        cause_rd[CAUSE_BD]               = bd_q;
        case (addr_r)
            REG_COUNT:   data_o = count;
            REG_COMPARE: data_o = compare;
            REG_SR:      data_o = sr_rd;
            REG_CAUSE:   data_o = cause_rd;
            REG_EPC:     data_o = epc_q;
            REG_PRID:    data_o = PRID;
            default:     data_o = DEFAULT_RDATA;
        endcase
    end

    assign epc = epc_q;

endmodule

// File: tb/tb_cp0_timer.sv
// Directed bench for cp0_timer: word-level architectural model checked
// every cycle, plus hand-computed literal expectations.
module tb_cp0_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  addr_r, addr_w;
  logic [31:0] data_i, data_o, pc, epc;
  logic        bd, exc_valid, eret, take;
  logic [4:0]  exc_code;
  logic [5:0]  hw_int;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  localparam logic [31:0] SR_MASK = 32'h0000_FC03;
  localparam logic [31:0] IM_IP_FIELD = 32'h0000_FC00;
  localparam int          TL_BIT = 15;

  // architectural model: whole SR/Cause words, TI kept apart from Cause
  logic [31:0] m_count, m_compare, m_sr, m_cause, m_epc;
  logic        m_ti;

  always #5 clk = ~clk;

  cp0_timer dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .addr_r    (addr_r),
    .addr_w    (addr_w),
    .data_i    (data_i),
    .data_o    (data_o),
    .pc        (pc),
    .bd        (bd),
    .exc_valid (exc_valid),
    .exc_code  (exc_code),
    .hw_int    (hw_int),
    .eret      (eret),
    .take      (take),
    .epc       (epc)
  );

  function automatic logic m_take();
    logic pend;
    pend = ((m_cause & m_sr & IM_IP_FIELD) != 32'd0) && m_sr[0] && !m_sr[1];
    return (exc_valid || pend) && !m_sr[1];
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_sr;
      5'd13:   return m_cause | (32'(m_ti) << 30);
      5'd14:   return m_epc;
      5'd15:   return 32'h2333_6666;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic nx_ti();
    if (we && addr_w == 5'd11) return 1'b0;
    if (m_count == m_compare && m_compare != 32'd0) return 1'b1;
    return m_ti;
  endfunction

  function automatic logic [31:0] nx_sr();
    logic [31:0] s = m_sr;
    if (we && addr_w == 5'd12) s = data_i & SR_MASK;
    if (eret) s[1] = 1'b0;
    if (m_take()) s[1] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] nx_epc();
    logic [31:0] e = m_epc;
    if (we && addr_w == 5'd14) e = data_i;
    if (m_take()) e = bd ? pc - 32'd4 : pc;
    return e;
  endfunction

  function automatic logic [31:0] nx_cause();
    logic [31:0] c = m_cause;
    if (!m_sr[1]) begin
      c[15:10] = hw_int;
      if (m_ti) c[TL_BIT] = 1'b1;
    end
    if (m_take()) begin
      c[31]  = bd;
      c[6:2] = exc_valid ? exc_code : 5'd0;
    end
    return c;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_count   <= 32'd0;
      m_compare <= 32'd0;
      m_ti      <= 1'b0;
      m_sr      <= 32'h0000_FC01;
      m_cause   <= 32'd0;
      m_epc     <= 32'd0;
    end else begin
      m_count   <= (we && addr_w == 5'd9) ? data_i : m_count + 32'd1;
      m_compare <= (we && addr_w == 5'd11) ? data_i : m_compare;
      m_ti      <= nx_ti();
      m_sr      <= nx_sr();
      m_cause   <= nx_cause();
      m_epc     <= nx_epc();
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model_take", 32'(take), 32'(m_take()));
      cmp("model_epc", epc, m_epc);
      cmp("model_data_o", data_o, m_read(addr_r));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; addr_r = 5'd12; addr_w = 5'd0; data_i = 32'd0;
    pc = 32'd0; bd = 1'b0; exc_valid = 1'b0; exc_code = 5'd0; hw_int = 6'd0; eret = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;

    // reset values of every readable register
    #1 cmp("rst_take", 32'(take), 32'd0);
    addr_r = 5'd12; #1 cmp("rst_sr", data_o, 32'h0000_FC01);
    addr_r = 5'd13; #1 cmp("rst_cause", data_o, 32'h0000_0000);
    addr_r = 5'd14; #1 cmp("rst_epc", data_o, 32'h0000_0000);
    addr_r = 5'd15; #1 cmp("rst_prid", data_o, 32'h2333_6666);
    addr_r = 5'd3;  #1 cmp("rst_unimpl", data_o, 32'hDEAD_BEEF);

    // hardware interrupt on line 2
    tick(); hw_int = 6'b000100; pc = 32'h3000; bd = 1'b0;
    #1 cmp("int_take_c0", 32'(take), 32'd0);
    tick(); cmp("int_take_c1", 32'(take), 32'd1);
    tick(); cmp("int_epc", epc, 32'h3000);
    addr_r = 5'd13; #1 cmp("int_cause", data_o, 32'h0000_1000);
    addr_r = 5'd12; #1 cmp("int_sr", data_o, 32'h0000_FC03);
    cmp("int_take_held", 32'(take), 32'd0);
    tick(); tick(); cmp("int_take_held2", 32'(take), 32'd0);

    // leave handler with IE off so the frozen IP cannot re-enter
    tick(); we = 1'b1; addr_w = 5'd12; data_i = 32'h0000_FC02; hw_int = 6'd0;
    tick(); we = 1'b0; eret = 1'b1;
    tick(); eret = 1'b0; addr_r = 5'd12;
    #1 cmp("eret_sr", data_o, 32'h0000_FC00);
    tick(); we = 1'b1; addr_w = 5'd12; data_i = 32'h0000_FC01;

    // exception and interrupt together in a delay slot
    tick(); we = 1'b0; hw_int = 6'b000001;
    #1 cmp("pre_exc_take", 32'(take), 32'd0);
    tick(); exc_valid = 1'b1; exc_code = 5'd4; bd = 1'b1; pc = 32'h3010;
    #1 cmp("exc_take", 32'(take), 32'd1);
    tick(); exc_valid = 1'b0; bd = 1'b0;
    #1 cmp("exc_epc", epc, 32'h300C);
    addr_r = 5'd13; #1 cmp("exc_cause", data_o, 32'h8000_0410);

    // exception while EXL=1 is ignored
    exc_valid = 1'b1; exc_code = 5'd8; pc = 32'h5000;
    #1 cmp("ign_take", 32'(take), 32'd0);
    tick(); exc_valid = 1'b0;
    #1 cmp("ign_epc", epc, 32'h300C);
    cmp("ign_cause", data_o, 32'h8000_0410);

    tick(); hw_int = 6'd0; we = 1'b1; addr_w = 5'd12; data_i = 32'h0000_FC02;
    tick(); we = 1'b0; eret = 1'b1;
    tick(); eret = 1'b0; addr_r = 5'd12;
    #1 cmp("eret2_sr", data_o, 32'h0000_FC00);
    tick(); we = 1'b1; addr_w = 5'd12; data_i = 32'h0000_FC01;

    // timer: Compare=10, Count=0
    tick(); addr_w = 5'd11; data_i = 32'd10;
    tick(); addr_w = 5'd9; data_i = 32'd0;
    tick(); we = 1'b0; addr_r = 5'd9;
    #1 cmp("cnt_load", data_o, 32'd0);
    repeat (10) tick();
    cmp("cnt_10", data_o, 32'd10);
    cmp("cnt_10_take", 32'(take), 32'd0);
    addr_r = 5'd13;
    tick(); cmp("ti_set", data_o, 32'hC000_0010);
    cmp("ti_set_take", 32'(take), 32'd0);
    tick(); cmp("ti_take", 32'(take), 32'd1);
    cmp("ti_ip", data_o, 32'hC000_8010);
    tick(); cmp("ti_epc", epc, 32'h5000);
    cmp("ti_cause", data_o, 32'h4000_8000);
    we = 1'b1; addr_w = 5'd11; data_i = 32'd0;
    tick(); we = 1'b0;
    #1 cmp("ti_clr", data_o, 32'h0000_8000);

    // Count wrap
    we = 1'b1; addr_w = 5'd9; data_i = 32'hFFFF_FFFF; addr_r = 5'd9;
    tick(); we = 1'b0;
    #1 cmp("cnt_max", data_o, 32'hFFFF_FFFF);
    tick(); cmp("cnt_wrap", data_o, 32'd0);

    // reset inside handler beats MTC0, ERET and exceptions
    reset = 1'b1; we = 1'b1; addr_w = 5'd12; data_i = 32'd0; eret = 1'b1; exc_valid = 1'b1;
    tick(); reset = 1'b0; we = 1'b0; eret = 1'b0; exc_valid = 1'b0; addr_r = 5'd12;
    #1 cmp("rst2_sr", data_o, 32'h0000_FC01);
    cmp("rst2_take", 32'(take), 32'd0);
    cmp("rst2_epc", epc, 32'd0);
    addr_r = 5'd13; #1 cmp("rst2_cause", data_o, 32'd0);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cp0_timer.md
CP0_TIMER -- requirements
Module: cp0_timer

Interface
REQ-001 Parameter N_HWINT, default 6, number of hardware interrupt lines (1..6); lines map to Cause/SR bits [9+N_HWINT:10].
REQ-002 Parameter PRID, default 32'h2333_6666, PRId read value.
REQ-003 Parameter TIMER_LINE, default N_HWINT-1, IP line onto which timer interrupt is ORed.
REQ-004 Port clk, input, 1, clock.
REQ-005 Port reset, input, 1, synchronous, active-high.
REQ-006 Port we, input, 1, MTC0 write enable.
REQ-007 Port addr_r, input, 5, MFC0 register number.
REQ-008 Port addr_w, input, 5, MTC0 register number.
REQ-009 Port data_i, input, 32, MTC0 data.
REQ-010 Port data_o, output, 32, MFC0 data (combinational).
REQ-011 Port pc, input, 32, PC of the instruction being interrupted or faulting.
REQ-012 Port bd, input, 1, that instruction is in a branch delay slot.
REQ-013 Port exc_valid, input, 1, synchronous exception present this cycle.
REQ-014 Port exc_code, input, 5, exception code when exc_valid.
REQ-015 Port hw_int, input, N_HWINT, level-sensitive device interrupts.
REQ-016 Port eret, input, 1, ERET retiring.
REQ-017 Port take, output, 1, redirect the pipeline to the handler this cycle.
REQ-018 Port epc, output, 32, current EPC.

Function
REQ-019 Registers: Count(9), Compare(11), SR(12), Cause(13), EPC(14), PRId(15); data_o returns 32'hDEAD_BEEF for any other addr_r.
REQ-020 SR fields: IE bit0, EXL bit1, IM bits[9+N_HWINT:10]; unimplemented bits read 0.
REQ-021 Cause fields: ExcCode[6:2], IP[9+N_HWINT:10], TI bit30, BD bit31; Cause is not writable by MTC0.
REQ-022 Count increments by 1 every cycle, wraps 32'hFFFF_FFFF->0; an MTC0 to Count loads data_i and the increment resumes the next cycle.
REQ-023 When Count==Compare and Compare!=0, TI sets on the next edge and stays set until an MTC0 to Compare clears it.
REQ-024 IP is sampled from hw_int every cycle while EXL=0; line TIMER_LINE samples hw_int[TIMER_LINE] OR TI.
REQ-025 int_pending = |(IP & IM) & IE & ~EXL, computed from the registered IP.
REQ-026 take = (exc_valid | int_pending) & ~EXL, combinational.
REQ-027 When take is high, the next edge sets EXL=1, BD<=bd, EPC<=bd ? pc-4 : pc, ExcCode<=exc_valid ? exc_code : 0.
REQ-028 When exc_valid and int_pending are both high, the exception wins: its code is recorded.
REQ-029 When exc_valid is high while EXL=1, the exception is ignored: take=0 and no state change.
REQ-030 When eret is high, the next edge clears EXL; eret with take high is a protocol error and take wins.
REQ-031 MTC0 to SR or EPC in the same cycle as take: take-driven EXL and EPC updates win; all other SR bits are written from data_i.
REQ-032 MTC0 to PRId or Cause is ignored.

Reset
REQ-033 On reset: SR=32'h0000_FC01 masked to implemented bits, with IE=1, EXL=0 and all IM set.
REQ-034 On reset: Cause=0, EPC=0, Count=0, Compare=0, TI=0, so take=0 in the cycle after reset.
REQ-035 reset asserted mid-handler (EXL=1) returns to the reset state; it has priority over we, take and eret.

Structure
REQ-036 A shared package cp0_pkg holds the register-number constants, SR/Cause field bit positions, ExcCode constants and the DEAD_BEEF default.
REQ-037 Sub-module cp0_timer_cnt contains Count, Compare and TI, with ports clk, reset, we_count, we_compare, data_i, count, compare and ti.

Verification
REQ-038 Reset, then read addr 12/13/14/15/3 -> 32'h0000_FC01, 0, 0, 32'h2333_6666, 32'hDEAD_BEEF.
REQ-039 Assert hw_int=6'b000100 with pc=32'h3000 and bd=0 -> take=1 one cycle later; next edge EPC=32'h3000, ExcCode=0, EXL=1; take=0 while hw_int is held.
REQ-040 exc_valid=1, exc_code=5'd4 and hw_int active in the same cycle, with bd=1 and pc=32'h3010 -> ExcCode=4, BD=1, EPC=32'h300C.
REQ-041 MTC0 Compare=10, MTC0 Count=0 -> TI sets when Count reaches 10 and take fires; MTC0 Compare=0 clears TI.
REQ-042 Set Count=32'hFFFF_FFFF -> reads 0 two cycles later; exc_valid pulsed while EXL=1 -> EPC unchanged; eret -> EXL=0 next cycle.
